// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory_unit port among NUM_REQ requesters.
// Sequences each transaction (issue, busy, done) and guards it with a watchdog.
module mem_arbiter #(
  parameter int NUM_REQ = 5,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [2*NUM_REQ-1:0]       func_in,
  input  logic [ADDR_W*NUM_REQ-1:0]  addr1_in,
  input  logic [ADDR_W*NUM_REQ-1:0]  addr2_in,
  input  logic [DATA_W*NUM_REQ-1:0]  wdata_in,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [NUM_REQ-1:0]         done,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic [1:0]                 mem_func,
  output logic                       mem_execute,
  output logic [ADDR_W-1:0]          address1,
  output logic [ADDR_W-1:0]          address2,
  output logic [DATA_W-1:0]          write_data,
  input  logic                       mem_ready,
  output logic                       timeout_err
);
  localparam int ID_W = $clog2(NUM_REQ);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RELEASE} state_t;

  state_t            state_reg;
  logic [NUM_REQ-1:0] gnt_reg;
  logic [NUM_REQ-1:0] done_reg;
  logic [ID_W-1:0]    id_reg;
  logic [ID_W-1:0]    ptr_reg;
  logic               exec_reg;
  logic               terr_reg;
  logic [7:0]         cnt_reg;
  logic [7:0]         cnt_next;

  logic               win_found;
  logic [ID_W-1:0]    win_idx;
  logic [ID_W:0]      cand;

  // First set request strictly after the pointer, wrapping at NUM_REQ-1.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, ptr_reg} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(NUM_REQ))
        cand = cand - (ID_W+1)'(NUM_REQ);
      if (!win_found && req[cand[ID_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[ID_W-1:0];
      end
    end
  end

  assign cnt_next = cnt_reg + 8'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      gnt_reg   <= '0;
      done_reg  <= '0;
      id_reg    <= '0;
      ptr_reg   <= ID_W'(NUM_REQ - 1);
      exec_reg  <= 1'b0;
      terr_reg  <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      done_reg <= '0;
      exec_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (win_found && mem_ready) begin
            gnt_reg   <= NUM_REQ'(1) << win_idx;
            id_reg    <= win_idx;
            ptr_reg   <= win_idx;
            cnt_reg   <= '0;
            exec_reg  <= 1'b1;
            state_reg <= ISSUE;
          end
        end
        ISSUE: state_reg <= WAIT_BUSY;
        WAIT_BUSY, WAIT_DONE: begin
          cnt_reg <= cnt_next;
          if (state_reg == WAIT_DONE && mem_ready) begin
            done_reg  <= gnt_reg;
            state_reg <= RELEASE;
          end else if (cnt_next >= TO_LAST) begin
            // Watchdog expiry lands RELEASE exactly TIMEOUT cycles after ISSUE.
            done_reg  <= gnt_reg;
            terr_reg  <= 1'b1;
            state_reg <= RELEASE;
          end else if (state_reg == WAIT_BUSY && !mem_ready) begin
            state_reg <= WAIT_DONE;
          end
        end
        RELEASE: begin
          gnt_reg   <= '0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  logic [1:0]        func_sel  [NUM_REQ];
  logic [ADDR_W-1:0] addr1_sel [NUM_REQ];
  logic [ADDR_W-1:0] addr2_sel [NUM_REQ];
  logic [DATA_W-1:0] wdata_sel [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
    assign func_sel[gi]  = gnt_reg[gi] ? func_in[2*gi +: 2]            : '0;
    assign addr1_sel[gi] = gnt_reg[gi] ? addr1_in[ADDR_W*gi +: ADDR_W] : '0;
    assign addr2_sel[gi] = gnt_reg[gi] ? addr2_in[ADDR_W*gi +: ADDR_W] : '0;
    assign wdata_sel[gi] = gnt_reg[gi] ? wdata_in[DATA_W*gi +: DATA_W] : '0;
  end

  // One-hot grant makes the AND-OR reduction a plain mux; no grant gives zeros.
  always_comb begin
    mem_func   = '0;
    address1   = '0;
    address2   = '0;
    write_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      mem_func   = mem_func   | func_sel[i];
      address1   = address1   | addr1_sel[i];
      address2   = address2   | addr2_sel[i];
      write_data = write_data | wdata_sel[i];
    end
  end

  assign gnt         = gnt_reg;
  assign done        = done_reg;
  assign grant_id    = id_reg;
  assign mem_execute = exec_reg;
  assign timeout_err = terr_reg;

endmodule
